// File: rtl/cache_ctrl_assoc.sv
// cache_ctrl_assoc: set-associative cache controller FSM with round-robin victims, pipelined fill and memory back-pressure.
module cache_ctrl_assoc #(
  parameter int WAYS = 2,
  parameter int WORDS = 4,
  parameter int MEM_LAT = 2,
  parameter int SET_BITS = 8,
  localparam int OFF = $clog2(WORDS),
  localparam int PW = WAYS > 1 ? $clog2(WAYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd,
  input  logic                wr,
  input  logic [SET_BITS-1:0] index,
  input  logic [WAYS-1:0]     way_hit,
  input  logic [WAYS-1:0]     way_valid,
  input  logic [WAYS-1:0]     way_dirty,
  input  logic                cache_err,
  input  logic                mem_err,
  input  logic                mem_stall,
  output logic                comp,
  output logic                cache_write,
  output logic                valid_in,
  output logic [WAYS-1:0]     way_en,
  output logic [OFF-1:0]      cache_offset,
  output logic [OFF-1:0]      mem_offset,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                victim_tag_sel,
  output logic                done,
  output logic                hit,
  output logic                stall,
  output logic                err
);
  typedef enum logic [2:0] {IDLE, WB, FILL, RETRY, DONE_HIT, DONE_MISS, ERR} state_t;
  state_t           state;
  logic [PW-1:0]    v, w, hit_way, vict;
  logic [OFF-1:0]   k, r;
  logic [OFF:0]     i;
  logic [MEM_LAT-1:0] pipe;
  logic [PW-1:0]    ptr [2**SET_BITS];
  logic [WAYS-1:0]  hv, v_oh;
  logic             hit_any, ret, acc;
  assign hv = way_hit & way_valid;
  assign hit_any = |hv;
  assign v_oh = WAYS'(1) << v;
  assign ret = pipe[MEM_LAT-1];
  assign acc = state == FILL && !i[OFF] && !mem_stall;
  // lowest hitting way; victim is the lowest invalid way, else the set's pointer
  always_comb begin
    hit_way = '0;
    vict = WAYS > 1 ? ptr[index] : '0;
    for (int j = WAYS - 1; j >= 0; j--) begin
      if (hv[j]) hit_way = PW'(j);
      if (!way_valid[j]) vict = PW'(j);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      v <= '0;
      w <= '0;
      k <= '0;
      r <= '0;
      i <= '0;
      pipe <= '0;
      for (int s = 0; s < 2**SET_BITS; s++) ptr[s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          k <= '0;
          r <= '0;
          i <= '0;
          pipe <= '0;
          if (rd & wr) state <= ERR;
          else if (rd ^ wr) begin
            if (hit_any) begin
              w <= hit_way;
              state <= DONE_HIT;
            end else if (cache_err) state <= ERR;
            else begin
              v <= vict;
              w <= vict;
              state <= way_valid[vict] & way_dirty[vict] ? WB : FILL;
            end
          end
        end
        WB: if (!mem_stall) begin
          k <= k + OFF'(1);
          if (&k) state <= FILL;
        end
        FILL: begin
          pipe <= (pipe << 1) | MEM_LAT'(acc);
          if (acc) i <= i + (OFF+1)'(1);
          if (ret) r <= r + OFF'(1);
          if (mem_err) begin
            pipe <= '0;
            state <= ERR;
          end else if (ret && &r) state <= RETRY;
        end
        RETRY: state <= DONE_MISS;
        DONE_HIT, DONE_MISS: begin
          if (WAYS > 1) ptr[index] <= w + PW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // rst gates the only input-dependent state so outputs drop the instant reset rises
  always_comb begin
    comp = 1'b0;
    cache_write = 1'b0;
    valid_in = 1'b0;
    way_en = '0;
    cache_offset = '0;
    mem_offset = '0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    victim_tag_sel = 1'b0;
    done = 1'b0;
    hit = 1'b0;
    stall = 1'b0;
    err = 1'b0;
    case (state)
      IDLE: if (!rst && (rd | wr)) begin
        stall = (rd & wr) | ~hit_any;
        if (rd ^ wr) begin
          comp = 1'b1;
          cache_write = wr;
          way_en = '1;
        end
      end
      WB: begin
        stall = 1'b1;
        way_en = v_oh;
        victim_tag_sel = 1'b1;
        mem_wr = 1'b1;
        cache_offset = k;
        mem_offset = k;
      end
      FILL: begin
        stall = 1'b1;
        mem_rd = !i[OFF];
        mem_offset = i[OFF-1:0];
        if (ret) begin
          cache_write = 1'b1;
          valid_in = 1'b1;
          way_en = v_oh;
          cache_offset = r;
        end
      end
      RETRY: begin
        stall = 1'b1;
        comp = 1'b1;
        cache_write = wr;
        way_en = v_oh;
      end
      DONE_HIT: begin
        done = 1'b1;
        hit = 1'b1;
      end
      DONE_MISS: done = 1'b1;
      ERR: begin
        done = 1'b1;
        err = 1'b1;
      end
      default: done = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// tb_cache_ctrl_assoc: directed timing checks of the 2-way, 4-word, latency-2 controller.
module tb_cache_ctrl_assoc;
  logic clk = 1'b0, rst = 1'b1;
  logic rd = 1'b0, wr = 1'b0;
  logic [7:0] index = '0;
  logic [1:0] way_hit = '0, way_valid = '0, way_dirty = '0;
  logic cache_err = 1'b0, mem_err = 1'b0, mem_stall = 1'b0;
  logic comp, cache_write, valid_in, mem_rd, mem_wr, victim_tag_sel, done, hit, stall, err;
  logic [1:0] way_en, cache_offset, mem_offset;
  logic [15:0] outv;
  int n_tests = 0, n_fail = 0;
  assign outv = {comp, cache_write, valid_in, way_en, cache_offset, mem_offset, mem_rd, mem_wr,
                 victim_tag_sel, done, hit, stall, err};
  cache_ctrl_assoc dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .index(index),
    .way_hit(way_hit), .way_valid(way_valid), .way_dirty(way_dirty),
    .cache_err(cache_err), .mem_err(mem_err), .mem_stall(mem_stall),
    .comp(comp), .cache_write(cache_write), .valid_in(valid_in), .way_en(way_en),
    .cache_offset(cache_offset), .mem_offset(mem_offset), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .victim_tag_sel(victim_tag_sel), .done(done), .hit(hit), .stall(stall), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // cycle 0 is the request cycle; expected first-event cycles are -1 when the event must not occur
  task automatic run_req(input string tag, input logic is_wr, input logic [7:0] idx,
                         input logic [1:0] val, dty, hv, input int st_lo, st_hi,
                         input int e_wb, e_rd, e_fw, e_retry, e_done,
                         input logic [1:0] e_way, input logic e_hit);
    int wb_c = -1, rd_c = -1, fw_c = -1, rt_c = -1, dn_c = -1;
    int nwb = 0, nrd = 0, nfw = 0, rt_cw = 0, got_hit = 0;
    for (int c = 0; c < 40 && dn_c < 0; c++) begin
      @(negedge clk);
      rd = !is_wr;
      wr = is_wr;
      index = idx;
      way_valid = val;
      way_dirty = dty;
      way_hit = hv;
      mem_stall = c >= st_lo && c <= st_hi;
      #1;
      if (c == 0) chk({tag, "_comp0"}, comp, 1);
      if (mem_wr) begin
        if (wb_c < 0) wb_c = c;
        chk({tag, "_wb_off"}, mem_offset, nwb);
        chk({tag, "_wb_tagsel"}, victim_tag_sel, 1);
        if (!mem_stall) nwb++;
      end
      if (mem_rd) begin
        if (rd_c < 0) rd_c = c;
        chk({tag, "_rd_off"}, mem_offset, nrd);
        if (!mem_stall) nrd++;
      end
      if (cache_write && valid_in) begin
        if (fw_c < 0) fw_c = c;
        chk({tag, "_fill_off"}, cache_offset, nfw);
        chk({tag, "_fill_way"}, way_en, e_way);
        nfw++;
      end
      if (comp && c > 0) begin
        rt_c = c;
        rt_cw = cache_write;
      end
      if (done) begin
        dn_c = c;
        got_hit = hit;
        chk({tag, "_done_stall"}, stall, 0);
      end
    end
    chk({tag, "_wb_first"}, wb_c, e_wb);
    chk({tag, "_rd_first"}, rd_c, e_rd);
    chk({tag, "_fill_first"}, fw_c, e_fw);
    chk({tag, "_retry"}, rt_c, e_retry);
    chk({tag, "_retry_cw"}, rt_cw, e_retry < 0 ? 0 : int'(is_wr));
    chk({tag, "_done"}, dn_c, e_done);
    chk({tag, "_hit"}, got_hit, e_hit);
    chk({tag, "_n_wb"}, nwb, e_wb < 0 ? 0 : 4);
    chk({tag, "_n_rd"}, nrd, e_rd < 0 ? 0 : 4);
    chk({tag, "_n_fill"}, nfw, e_fw < 0 ? 0 : 4);
    @(negedge clk);
    rd = 1'b0;
    wr = 1'b0;
    mem_stall = 1'b0;
    #1;
    chk({tag, "_idle"}, int'(outv), 0);
  endtask
  initial begin
    #1;
    chk("reset_outs", int'(outv), 0);
    rd = 1'b1;
    #1;
    chk("reset_gates_req", int'(outv), 0);
    rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_outs", int'(outv), 0);
    // index 5: hit way0 moves ptr to 1, so the next all-valid miss evicts way1, then ptr returns to 0
    run_req("hit_w0", 1'b0, 8'd5, 2'b11, 2'b00, 2'b01, 99, 99, -1, -1, -1, -1, 1, 2'b00, 1'b1);
    run_req("rr_miss", 1'b0, 8'd5, 2'b11, 2'b00, 2'b00, 99, 99, -1, 1, 3, 7, 8, 2'b10, 1'b0);
    run_req("dirty_wr", 1'b1, 8'd5, 2'b11, 2'b01, 2'b00, 99, 99, 1, 5, 7, 11, 12, 2'b01, 1'b0);
    run_req("hit_w1", 1'b0, 8'd5, 2'b11, 2'b00, 2'b10, 99, 99, -1, -1, -1, -1, 1, 2'b00, 1'b1);
    run_req("ptr_back0", 1'b0, 8'd5, 2'b11, 2'b00, 2'b00, 99, 99, -1, 1, 3, 7, 8, 2'b01, 1'b0);
    run_req("clean_rd", 1'b0, 8'd7, 2'b01, 2'b00, 2'b00, 99, 99, -1, 1, 3, 7, 8, 2'b10, 1'b0);
    run_req("bp", 1'b0, 8'd8, 2'b00, 2'b00, 2'b00, 2, 3, -1, 1, 3, 9, 10, 2'b01, 1'b0);
    // rd and wr together
    @(negedge clk);
    rd = 1'b1;
    wr = 1'b1;
    #1;
    chk("rdwr_c0_stall", stall, 1);
    chk("rdwr_c0_comp", comp, 0);
    chk("rdwr_c0_cw", cache_write, 0);
    @(negedge clk);
    #1;
    chk("rdwr_c1_err", {done, err}, 3);
    chk("rdwr_c1_mem", {cache_write, mem_rd}, 0);
    @(negedge clk);
    rd = 1'b0;
    wr = 1'b0;
    #1;
    chk("rdwr_idle", int'(outv), 0);
    // mem_err in FILL at cycle 3
    @(negedge clk);
    rd = 1'b1;
    index = 8'd10;
    way_valid = 2'b01;
    way_hit = 2'b00;
    way_dirty = 2'b00;
    #1;
    chk("merr_c0_stall", stall, 1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    mem_err = 1'b1;
    #1;
    chk("merr_c3_fill", {cache_write, valid_in}, 3);
    @(negedge clk);
    mem_err = 1'b0;
    #1;
    chk("merr_c4_err", {done, err, hit}, 6);
    chk("merr_c4_mem", {mem_rd, cache_write}, 0);
    @(negedge clk);
    rd = 1'b0;
    #1;
    chk("merr_idle", int'(outv), 0);
    // reset asserted mid-FILL
    @(negedge clk);
    rd = 1'b1;
    index = 8'd9;
    #1;
    chk("rstf_c0_stall", stall, 1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    #1;
    chk("rstf_c3_pre", {cache_write, mem_rd}, 3);
    rst = 1'b1;
    #1;
    chk("rstf_c3_outs", int'(outv), 0);
    @(negedge clk);
    rst = 1'b0;
    rd = 1'b0;
    #1;
    chk("rstf_c4_outs", int'(outv), 0);
    @(negedge clk);
    #1;
    chk("rstf_c5_outs", int'(outv), 0);
    run_req("after_rst", 1'b0, 8'd9, 2'b01, 2'b00, 2'b00, 99, 99, -1, 1, 3, 7, 8, 2'b10, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_ctrl_assoc.md
# cache_ctrl_assoc

Parametrised set-associative cache controller FSM. It sits between the processor memory stage and the banked main memory, and drives the way-array datapath: compare, write, valid, way select and word offset. It adds four things to the single-way controller: a configurable number of ways with per-set round-robin victim selection, configurable line length, configurable memory latency with a pipelined fill, and memory back-pressure.

## Interface
- WAYS, 2: ways per set; legal values 1, 2, 4.
- WORDS, 4: words per line; power of two, at least 2. OFF = clog2(WORDS).
- MEM_LAT, 2: cycles from an accepted mem_rd to its data return; range 1..8.
- SET_BITS, 8: index width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd, wr  in  1 each  request strobes; held with index until done.
- index  in  SET_BITS  set of the current request.
- way_hit, way_valid, way_dirty  in  WAYS each  per-way compare/status from the datapath; meaningful in the same cycle as the compare.
- cache_err, mem_err  in  1 each  datapath and memory error flags.
- mem_stall  in  1  memory rejects this cycle's mem_rd or mem_wr.
- comp, cache_write, valid_in  out  1 each  way-array controls.
- way_en  out  WAYS  one-hot way select, or all ones during compare.
- cache_offset, mem_offset  out  OFF each  word within line.
- mem_rd, mem_wr, victim_tag_sel  out  1 each  memory strobes; victim_tag_sel selects the victim tag onto the memory address.
- done, hit, stall, err  out  1 each  processor-side status.

## Operation
- **States:** IDLE, WB, FILL, RETRY, DONE_HIT, DONE_MISS, ERR.
- **Defaults:** every output is 0 except way_en = 0. Reset forces IDLE, clears all counters and the return pipeline, and sets every per-set pointer ptr[set] to 0.

**IDLE**
- Idle with no request: stall = 0.
- On rd XOR wr: drive comp = 1, cache_write = wr, way_en = all ones. The datapath gates the write with the hit way.
  - Any way_hit & way_valid goes to DONE_HIT.
  - cache_err goes to ERR.
  - Otherwise latch victim v, then go to WB if way_valid[v] & way_dirty[v], else FILL.
- Victim choice: the lowest-index invalid way; if all ways are valid, ptr[index].
- rd & wr together: go to ERR with no array access.

**WB**
- Drive comp = 0, cache_write = 0, way_en = onehot(v), victim_tag_sel = 1, mem_wr = 1.
- cache_offset = mem_offset = k.
- k advances only when mem_stall = 0. Acceptance of k = WORDS-1 goes to FILL with k cleared.

**FILL**
- Issue side: mem_rd = 1 with mem_offset = i while i < WORDS. i advances when mem_stall = 0.
- Accepted issues enter a MEM_LAT-deep return shift register.
- When a return emerges: cache_write = 1, valid_in = 1, way_en = onehot(v), cache_offset = r, then r increments.
- When return r = WORDS-1 is written, go to RETRY.
- mem_err on any cycle goes to ERR, and the in-flight returns are discarded.

**RETRY**
- Drive comp = 1, cache_write = wr, way_en = onehot(v). A write sets dirty through the datapath.
- Next state is DONE_MISS.

**DONE_HIT / DONE_MISS / ERR**
- All three drive done = 1 and stall = 0, then return to IDLE.
- DONE_HIT also drives hit = 1.
- ERR also drives err = 1.

**Pointer update**
- On DONE_HIT or DONE_MISS with way w: ptr[index] <= (w+1) mod WAYS. For WAYS = 2 this is true LRU.
- WAYS = 1: v = 0 always and the pointer logic is removed.

## Timing
- stall = 1 in WB, FILL and RETRY, and in IDLE during a request cycle that misses or errors. rd/wr are ignored outside IDLE.
- Hit: request in cycle 0, done/hit in cycle 1.
- Clean miss, no mem_stall: done in cycle WORDS+MEM_LAT+2. Defaults give cycle 8.
- Dirty miss, no mem_stall: done in cycle 2·WORDS+MEM_LAT+2. Defaults give cycle 12.
- Each mem_stall cycle adds exactly one cycle. Returns continue while issue is stalled.
- A new request may be presented in the cycle after done.
- Reset asserted mid-WB or mid-FILL takes effect immediately: IDLE, all outputs 0, no further mem strobes, and returns still in flight are discarded.

## Test plan
- **Read hit:** WAYS=2; rd, way_hit=2'b10, way_valid=2'b11 -> cycle 1 done=1, hit=1; ptr[index] becomes 0.
- **Clean read miss:** way_valid=2'b01 -> v=1; mem_rd on cycles 1-4 with offsets 0-3; cache writes on cycles 3-6 with valid_in=1; done on cycle 8 with hit=0.
- **Dirty write miss:** ptr=0, way_valid=2'b11, way_dirty=2'b01 -> mem_wr with victim_tag_sel on cycles 1-4, fill on cycles 5-10, RETRY comp=1 cache_write=1 on cycle 11, done on cycle 12.
- **Back-pressure:** mem_stall high on cycles 2-3 of a clean miss -> offset 1 reissued until accepted; done on cycle 10.
- **Errors:** mem_err during FILL -> next cycle done=1, err=1, then IDLE. rd & wr together -> cycle 1 err=1, with no cache_write or mem_rd asserted.
- **Reset mid-FILL:** rst on cycle 3 -> all outputs 0 immediately; a rd issued after rst is released behaves as the clean read miss case.
